// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and its environment: the unit under test on one
// side (vec out, f_in back) and the golden table / result indicators on the other.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic [NV-1:0]   expected;
  logic            f_in;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NV-1:0]   captured;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail;
  logic            fail_seen;

  modport slave (
    input  start, expected, f_in,
    output vec, busy, done, pass, captured, fail_count, first_fail, fail_seen
  );

  modport master (
    output start, expected, f_in,
    input  vec, busy, done, pass, captured, fail_count, first_fail, fail_seen
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N_IN-input combinational function, samples its
// output after a settle delay and scores it against a latched golden truth table.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int NV = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   settle_cnt;
  logic [NV-1:0]   exp_q;
  logic [N_IN-1:0] vec;
  logic [NV-1:0]   captured;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail;
  logic            fail_seen;
  logic            launch;
  logic            last_vec;
  logic            mismatch;

  assign last_vec = &vec;
  assign mismatch = bus.f_in != exp_q[vec];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (settle_cnt == CW'(1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Golden table is latched at launch so the port may change freely mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      exp_q      <= '0;
      vec        <= '0;
      captured   <= '0;
      fail_count <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else if (launch) begin
      settle_cnt <= CW'(SETTLE);
      exp_q      <= bus.expected;
      vec        <= '0;
      captured   <= '0;
      fail_count <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else if (state == WAIT) begin
      settle_cnt <= settle_cnt - CW'(1);
    end else if (state == SAMPLE) begin
      captured[vec] <= bus.f_in;
      if (mismatch) begin
        fail_count <= fail_count + (N_IN+1)'(1);
        if (!fail_seen) begin
          first_fail <= vec;
          fail_seen  <= 1'b1;
        end
      end
      if (!last_vec) begin
        vec        <= vec + N_IN'(1);
        settle_cnt <= CW'(SETTLE);
      end
    end
  end

  assign bus.vec        = vec;
  assign bus.busy       = (state == WAIT) || (state == SAMPLE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && (fail_count == '0);
  assign bus.captured   = captured;
  assign bus.fail_count = fail_count;
  assign bus.first_fail = first_fail;
  assign bus.fail_seen  = fail_seen;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table rows, randomized tables scored by a
// popcount/first-bit model, plus settle-length, ignored-start and reset cases.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) ifa ();
  truth_table_sweeper_if #(.N_IN(4)) ifb ();

  logic [15:0] ftab_a = '0;
  logic [15:0] ftab_b = '0;
  assign ifa.f_in = ftab_a[ifa.vec];
  assign ifb.f_in = ftab_b[ifb.vec];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic [15:0] captured;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail;
    logic        fail_seen;
    logic        pass;
  } res_t;

  typedef struct packed {
    logic [15:0] expected;
    logic [15:0] ftab;
    res_t        want;
  } row_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Result of a complete sweep follows directly from the two tables.
  function automatic res_t model(input logic [15:0] e, input logic [15:0] t);
    res_t r;
    logic [15:0] diff;
    diff = e ^ t;
    r.captured   = t;
    r.fail_count = '0;
    r.first_fail = '0;
    r.fail_seen  = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin
        r.fail_count = r.fail_count + 5'd1;
        r.first_fail = 4'(i);
        r.fail_seen  = 1'b1;
      end
    end
    r.pass = (diff == '0);
    return r;
  endfunction

  function automatic logic [15:0] f_good();
    logic [15:0] f;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      f[i] = (!v[3] && v[0]) || (!v[1] && v[0]);
    end
    return f;
  endfunction

  task automatic chk_res_a(input string tag, input res_t want);
    chk({tag, ".captured"},   64'(ifa.captured),   64'(want.captured));
    chk({tag, ".fail_count"}, 64'(ifa.fail_count), 64'(want.fail_count));
    chk({tag, ".first_fail"}, 64'(ifa.first_fail), 64'(want.first_fail));
    chk({tag, ".fail_seen"},  64'(ifa.fail_seen),  64'(want.fail_seen));
    chk({tag, ".pass"},       64'(ifa.pass),       64'(want.pass));
  endtask

  // One start pulse on the SETTLE=1 instance; the expected port is scrambled
  // after launch to show only the latched copy matters.
  task automatic run_a(input string tag, input logic [15:0] e, input logic [15:0] t,
                       input res_t want);
    int cyc;
    ftab_a = t;
    @(negedge clk);
    ifa.expected = e;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifa.expected = 16'($urandom);
    chk({tag, ".e0_busy"}, 64'(ifa.busy), 64'd1);
    chk({tag, ".e0_done"}, 64'(ifa.done), 64'd0);
    chk({tag, ".e0_vec"},  64'(ifa.vec),  64'd0);
    cyc = 0;
    while (!ifa.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'd32);
    chk({tag, ".busy_end"}, 64'(ifa.busy), 64'd0);
    chk_res_a(tag, want);
  endtask

  row_t rows[6];

  initial begin
    logic [15:0] fg;
    logic [15:0] e, t;
    int cyc;

    fg = f_good();
    rows[0] = '{16'h22AA, fg,      '{16'h22AA, 5'd0,  4'd0,  1'b0, 1'b1}};
    rows[1] = '{16'h0000, fg,      '{16'h22AA, 5'd6,  4'd1,  1'b1, 1'b0}};
    rows[2] = '{16'h22AA, 16'h0,   '{16'h0000, 5'd6,  4'd1,  1'b1, 1'b0}};
    rows[3] = '{16'h22AA, ~fg,     '{16'hDD55, 5'd16, 4'd0,  1'b1, 1'b0}};
    rows[4] = '{16'hFFFF, 16'hFFFF,'{16'hFFFF, 5'd0,  4'd0,  1'b0, 1'b1}};
    rows[5] = '{16'h8000, 16'h0,   '{16'h0000, 5'd1,  4'd15, 1'b1, 1'b0}};

    ifa.start = 1'b0; ifa.expected = '0;
    ifb.start = 1'b0; ifb.expected = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_a", 64'({ifa.vec, ifa.busy, ifa.done, ifa.pass, ifa.captured,
                        ifa.fail_count, ifa.first_fail, ifa.fail_seen}), 64'd0);
    chk("reset_b", 64'({ifb.vec, ifb.busy, ifb.done, ifb.pass, ifb.captured,
                        ifb.fail_count, ifb.first_fail, ifb.fail_seen}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 64'(ifa.busy), 64'd0);

    // Consecutive rows also exercise restart from DONE (row1 follows a pass).
    for (int r = 0; r < 6; r++)
      run_a($sformatf("row%0d", r), rows[r].expected, rows[r].ftab, rows[r].want);

    for (int k = 0; k < 6; k++) begin
      e = 16'($urandom);
      t = (k % 2 == 0) ? (e ^ (16'd1 << $urandom_range(15, 0))) : 16'($urandom);
      run_a($sformatf("rand%0d", k), e, t, model(e, t));
    end

    // SETTLE=3: vec advances every 4 cycles, a second start mid-sweep is ignored.
    ftab_b = fg;
    @(negedge clk);
    ifb.expected = 16'h22AA;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    chk("s3.e0_busy", 64'(ifb.busy), 64'd1);
    cyc = 0;
    while (!ifb.done && cyc < 200) begin
      if (cyc == 9) ifb.start = 1'b1;
      if (cyc == 10) ifb.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (cyc < 64)
        chk($sformatf("s3.vec_c%0d", cyc), 64'(ifb.vec), 64'(cyc / 4));
    end
    ifb.start = 1'b0;
    chk("s3.latency", 64'(cyc), 64'd64);
    chk("s3.vec_end", 64'(ifb.vec), 64'd15);
    chk("s3.captured", 64'(ifb.captured), 64'h22AA);
    chk("s3.fail_count", 64'(ifb.fail_count), 64'd0);
    chk("s3.pass", 64'(ifb.pass), 64'd1);

    // Reset mid-sweep at E0+13: vectors 0..5 have been sampled by then.
    e = 16'($urandom);
    t = 16'($urandom);
    ftab_a = t;
    @(negedge clk);
    ifa.expected = e;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("mid.partial", 64'(ifa.captured), 64'(t & 16'h003F));
    chk("mid.vec", 64'(ifa.vec), 64'd6);
    #2 rst = 1'b1;
    #1;
    chk("mid.reset_a", 64'({ifa.vec, ifa.busy, ifa.done, ifa.pass, ifa.captured,
                            ifa.fail_count, ifa.first_fail, ifa.fail_seen}), 64'd0);
    chk("mid.reset_b", 64'({ifb.vec, ifb.busy, ifb.done, ifb.pass, ifb.captured,
                            ifb.fail_count, ifb.first_fail, ifb.fail_seen}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.idle_after", 64'({ifa.busy, ifa.done}), 64'd0);
    run_a("post_reset", 16'h22AA, fg, model(16'h22AA, fg));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
